// File: rtl/quant_lane_arbiter_if.sv
// quant_lane_arbiter_if: lane request side and quantized result side of the lane arbiter.
interface quant_lane_arbiter_if #(
    parameter int N_LANES   = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int LANE_W    = $clog2(N_LANES)
);
    logic [N_LANES-1:0]          s_valid;
    logic [N_LANES*IN_WIDTH-1:0] s_data;
    logic [N_LANES-1:0]          s_ready;
    logic                        m_valid;
    logic [OUT_WIDTH-1:0]        m_data;
    logic [LANE_W-1:0]           m_lane;
    logic                        m_overflow;
    logic                        m_ready;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_lane, m_overflow
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_lane, m_overflow
    );
endinterface

// File: rtl/quant_lane_arbiter.sv
// quant_lane_arbiter: round-robin share of one saturating Q18.14 -> Q2.14 quantizer across MAC lanes.
// Per-lane saturation counters are built only when QUANT_ARB_SAT_CNT_EN is defined.
module quant_lane_arbiter #(
    parameter int N_LANES   = 4,
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int LANE_W    = $clog2(N_LANES)
) (
    input  logic                  clk,
    input  logic                  rst,
    quant_lane_arbiter_if.master  bus,
    output logic                  busy,
    input  logic                  cnt_clr,
    input  logic [LANE_W-1:0]     cnt_sel,
    output logic [15:0]           cnt_value
);
    localparam logic signed [IN_WIDTH-1:0] SAT_MAX = IN_WIDTH'((1 << (OUT_WIDTH-1)) - 1);
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN = -SAT_MAX - 1;

    logic                        stall;
    logic [LANE_W-1:0]           ptr;
    logic [LANE_W-1:0]           gnt_lane;
    logic [LANE_W-1:0]           k;
    logic                        gnt_any;
    logic                        acc;
    logic [IN_WIDTH-1:0]         gnt_data;
    logic                        s1_valid;
    logic signed [IN_WIDTH-1:0]  s1_data;
    logic [LANE_W-1:0]           s1_lane;
    logic                        sat_hi;
    logic                        sat_lo;
    logic [OUT_WIDTH-1:0]        sat_data;

    assign stall = bus.m_valid && !bus.m_ready;

    // Descending scan so the lane closest above the pointer wins.
    always_comb begin
        gnt_lane = '0;
        gnt_any  = 1'b0;
        k        = '0;
        for (int i = N_LANES-1; i >= 0; i--) begin
            k = LANE_W'((int'(ptr) + i) % N_LANES);
            if (bus.s_valid[k]) begin
                gnt_lane = k;
                gnt_any  = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < N_LANES; i++)
            if (LANE_W'(i) == gnt_lane) gnt_data = bus.s_data[i*IN_WIDTH +: IN_WIDTH];
    end

    assign bus.s_ready = (gnt_any && !stall) ? (N_LANES'(1) << gnt_lane) : '0;
    assign acc         = |(bus.s_valid & bus.s_ready);

    assign sat_hi   = s1_data > SAT_MAX;
    assign sat_lo   = s1_data < SAT_MIN;
    assign sat_data = sat_hi ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                      sat_lo ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : s1_data[OUT_WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr            <= '0;
            s1_valid       <= 1'b0;
            s1_data        <= '0;
            s1_lane        <= '0;
            bus.m_valid    <= 1'b0;
            bus.m_data     <= '0;
            bus.m_lane     <= '0;
            bus.m_overflow <= 1'b0;
        end else if (!stall) begin
            s1_valid    <= acc;
            bus.m_valid <= s1_valid;
            if (acc) begin
                s1_data <= gnt_data;
                s1_lane <= gnt_lane;
                ptr     <= (int'(gnt_lane) == N_LANES-1) ? '0 : gnt_lane + 1'b1;
            end
            if (s1_valid) begin
                bus.m_data     <= sat_data;
                bus.m_lane     <= s1_lane;
                bus.m_overflow <= sat_hi | sat_lo;
            end
        end
    end

    assign busy = s1_valid | bus.m_valid;

`ifdef QUANT_ARB_SAT_CNT_EN
    logic [15:0] sat_cnt [N_LANES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst || cnt_clr)
            sat_cnt <= '{default: '0};
        else if (bus.m_valid && bus.m_ready && bus.m_overflow && sat_cnt[bus.m_lane] != 16'hFFFF)
            sat_cnt[bus.m_lane] <= sat_cnt[bus.m_lane] + 16'd1;
    end

    assign cnt_value = sat_cnt[cnt_sel];
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_clr, cnt_sel};
    assign cnt_value  = '0;
`endif
endmodule

// File: doc/quant_lane_arbiter.md
Name: quant_lane_arbiter

Overview:
- Shares one saturating 32->16 quantizer (Q18.14 in, Q2.14 out) among N_LANES MAC accumulator lanes.
- Uses round-robin arbitration with valid/ready handshakes on both sides.
- Sits between the MAC array and the activation/writeback path.
- Output carries the source lane ID so results can be demultiplexed downstream.

Parameters:
- N_LANES, 4, number of requesting MAC lanes (>=2).
- IN_WIDTH, 32, accumulator width (Q18.14).
- OUT_WIDTH, 16, quantized width (Q2.14).
- LANE_W, $clog2(N_LANES), width of the lane ID.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  N_LANES  per-lane request; lane k is bit k.
- s_data  in  N_LANES*IN_WIDTH  lane k data at [k*IN_WIDTH +: IN_WIDTH], signed.
- s_ready  out  N_LANES  one-hot grant; lane k's word is accepted when s_valid[k] && s_ready[k].
- m_valid  out  1  quantized result valid.
- m_data  out  OUT_WIDTH  signed quantized result.
- m_lane  out  LANE_W  source lane of m_data.
- m_overflow  out  1  result was saturated.
- m_ready  in  1  downstream accepts result.
- busy  out  1  any pipeline stage holds data.
- cnt_clr  in  1  clears all saturation counters (optional feature).
- cnt_sel  in  LANE_W  counter read select (optional feature).
- cnt_value  out  16  saturation count of lane cnt_sel (optional feature).

Behaviour:
- Reset (async, rst=1):
  - m_valid=0, m_data=0, m_lane=0, m_overflow=0, busy=0.
  - Stage-1 valid=0; RR pointer=0; counters=0.
  - Reset asserted mid-transfer discards all in-flight words; nothing is replayed.
- Pipeline: 2 stages.
  - S1: captures the granted word and its lane ID.
  - S2: saturates and registers into the m_* outputs.
  - Latency is 2 cycles from the accepting edge to m_valid when unstalled.
  - Throughput is 1 word/cycle.
- Stall: stall = m_valid && !m_ready.
  - While stalled, S1 and S2 hold their contents and s_ready = 0.
  - When not stalled, S1 advances into S2 every cycle; S2 loads S1 valid (a bubble when S1 is empty).
- Arbitration:
  - s_ready is combinational from s_valid, the RR pointer and stall.
  - The grant goes to the first lane with s_valid set, scanning from the pointer upward with wrap.
  - At most one s_ready bit is high.
  - No grant when stalled or when no lane is valid.
  - After an accepted grant to lane k, pointer <= (k+1) mod N_LANES. Otherwise the pointer holds.
- Saturation (signed compare on IN_WIDTH):
  - d > +(2^(OUT_WIDTH-1)-1): out = 0x7FFF, overflow = 1.
  - d < -(2^(OUT_WIDTH-1)): out = 0x8000, overflow = 1.
  - Otherwise out = d[OUT_WIDTH-1:0], overflow = 0.
  - Boundary values 0x00007FFF and 0xFFFF8000 pass unsaturated.
- m_data, m_lane and m_overflow must remain stable while m_valid && !m_ready.
- busy = S1 valid | m_valid.

Optional Feature:
- Macro: QUANT_ARB_SAT_CNT_EN.
- Defined:
  - One 16-bit counter per lane, incremented when a saturated result is accepted downstream (m_valid && m_ready && m_overflow), indexed by m_lane.
  - Counters stick at 0xFFFF.
  - cnt_clr zeroes all counters; when cnt_clr coincides with an increment, the clear wins.
  - cnt_value = counter[cnt_sel], combinational read.
- Undefined: no counters; cnt_value tied to 0; cnt_clr and cnt_sel ignored. Ports remain present in both builds.

Test Plan:
- Single lane: lane 2 sends 0x00001234 with m_ready=1 -> two cycles later m_valid=1, m_data=0x1234, m_lane=2, m_overflow=0.
- Saturation: lane 0 sends 0x00010000, then 0xFFFE0000, then 0x00007FFF, then 0xFFFF8000.
  - Expected outputs: 0x7FFF/ovf=1, 0x8000/ovf=1, 0x7FFF/ovf=0, 0x8000/ovf=0.
- Fairness: all 4 lanes hold valid continuously for 8 cycles -> grants in order 0,1,2,3,0,1,2,3. No lane granted twice before the others.
- Backpressure:
  - Hold m_ready=0 for 5 cycles with two words in flight -> m_* outputs stable, s_ready=0.
  - Release -> both words emerge in order with no loss or duplication.
- Reset mid-stream: assert rst while S1 and S2 are full -> m_valid=0 and busy=0 immediately. After release, the first grant goes to the lowest valid lane starting from lane 0.
- Counters (QUANT_ARB_SAT_CNT_EN):
  - Three saturating words on lane 1 -> cnt_sel=1 reads cnt_value=3.
  - cnt_clr pulsed in the same cycle as a fourth saturated accept -> cnt_value=0.
